// File: rtl/rv32i_pkg.sv
// Memory-map constants shared by the LSU and its decode checker.
// Region k of the packed defaults sits at bits [k*32 +: 32].
package rv32i_pkg;

  localparam int MAX_REGIONS = 16;

  localparam logic [31:0] DATA_MEM_BASE_ADDR = 32'h0000_0000;
  localparam logic [31:0] LEDR_BASE_ADDR     = 32'h0000_7000;
  localparam logic [31:0] LEDG_BASE_ADDR     = 32'h0000_7010;
  localparam logic [31:0] SEG7_BASE_ADDR     = 32'h0000_7020;
  localparam logic [31:0] LCD_BASE_ADDR      = 32'h0000_7040;
  localparam logic [31:0] SW_BASE_ADDR       = 32'h0000_7800;
  localparam logic [31:0] BTN_BASE_ADDR      = 32'h0000_7810;
  localparam logic [31:0] TIMER_BASE_ADDR    = 32'h0000_7820;

  localparam logic [31:0] DATA_MEM_SIZE = 32'h0000_2000;
  localparam logic [31:0] LEDR_SIZE     = 32'h0000_0010;
  localparam logic [31:0] LEDG_SIZE     = 32'h0000_0010;
  localparam logic [31:0] SEG7_SIZE     = 32'h0000_0020;
  localparam logic [31:0] LCD_SIZE      = 32'h0000_0010;
  localparam logic [31:0] SW_SIZE       = 32'h0000_0010;
  localparam logic [31:0] BTN_SIZE      = 32'h0000_0010;
  localparam logic [31:0] TIMER_SIZE    = 32'h0000_0010;

  localparam logic [8*32-1:0] DEF_REGION_BASE = {
    TIMER_BASE_ADDR, BTN_BASE_ADDR, SW_BASE_ADDR, LCD_BASE_ADDR,
    SEG7_BASE_ADDR, LEDG_BASE_ADDR, LEDR_BASE_ADDR, DATA_MEM_BASE_ADDR
  };

  localparam logic [8*32-1:0] DEF_REGION_SIZE = {
    TIMER_SIZE, BTN_SIZE, SW_SIZE, LCD_SIZE,
    SEG7_SIZE, LEDG_SIZE, LEDR_SIZE, DATA_MEM_SIZE
  };

  // True when more than one bit of the select vector is set.
  function automatic logic multi_hot(input logic [MAX_REGIONS-1:0] v);
    return (v & (v - MAX_REGIONS'(1))) != '0;
  endfunction

endpackage

// File: rtl/lsu_region_match.sv
// Combinational address-to-region decode used as the checker's golden decoder.
// Flags addresses that fall into more than one region.
module lsu_region_match
  import rv32i_pkg::*;
#(
  parameter int                              NUM_REGIONS = 8,
  parameter int                              ADDR_W      = 32,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_SIZE = DEF_REGION_SIZE
) (
  input  logic                   vld,
  input  logic [ADDR_W-1:0]      addr,
  output logic [NUM_REGIONS-1:0] exp_vec,
  output logic                   overlap
);

  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_region
    localparam logic [ADDR_W-1:0] BASE = REGION_BASE[k*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W-1:0] SIZE = REGION_SIZE[k*ADDR_W +: ADDR_W];
    localparam logic              EN   = (SIZE != '0);

    // One extra bit: addresses below the base wrap to a huge offset, and a
    // region ending exactly at 2^ADDR_W still bounds correctly.
    logic [ADDR_W:0] offset;
    assign offset     = {1'b0, addr} - {1'b0, BASE};
    assign exp_vec[k] = vld && EN && (offset < {1'b0, SIZE});
  end

  assign overlap = multi_hot(MAX_REGIONS'(exp_vec));

endmodule

// File: rtl/lsu_decode_checker.sv
// Observational checker for the LSU address decoder: recomputes the select
// vector, aligns it to the decoder latency and tracks hits, errors and the first error.
module lsu_decode_checker
  import rv32i_pkg::*;
#(
  parameter int                              NUM_REGIONS = 8,
  parameter int                              ADDR_W      = 32,
  parameter int                              LATENCY     = 0,
  parameter int                              CNT_W       = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_SIZE = DEF_REGION_SIZE
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_drv_vld,
  input  logic [ADDR_W-1:0]            i_drv_addr,
  input  logic [NUM_REGIONS-1:0]       i_act_vld,
  input  logic                         i_clr,
  output logic                         o_err,
  output logic                         o_err_sticky,
  output logic [CNT_W-1:0]             o_err_cnt,
  output logic [NUM_REGIONS*CNT_W-1:0] o_hit_cnt,
  output logic [ADDR_W-1:0]            o_first_addr,
  output logic [NUM_REGIONS-1:0]       o_first_exp,
  output logic [NUM_REGIONS-1:0]       o_first_act,
  output logic                         o_overlap
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [NUM_REGIONS-1:0] exp_live;
  logic                   overlap_live;

  lsu_region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE)
  ) u_match (
    .vld     (i_drv_vld),
    .addr    (i_drv_addr),
    .exp_vec (exp_live),
    .overlap (overlap_live)
  );

  // ---- delay line: align expectation with the decoder's select outputs ----
  logic [NUM_REGIONS-1:0] exp_c;
  logic [ADDR_W-1:0]      addr_c;
  logic                   vld_c;

  if (LATENCY == 0) begin : g_nodly
    assign exp_c  = exp_live;
    assign addr_c = i_drv_addr;
    assign vld_c  = 1'b1;
  end else begin : g_dly
    logic [NUM_REGIONS-1:0] exp_p  [LATENCY];
    logic [ADDR_W-1:0]      addr_p [LATENCY];
    logic                   vld_p  [LATENCY];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int i = 0; i < LATENCY; i++) begin
          exp_p[i]  <= '0;
          addr_p[i] <= '0;
          vld_p[i]  <= 1'b0;
        end
      end else begin
        exp_p[0]  <= exp_live;
        addr_p[0] <= i_drv_addr;
        vld_p[0]  <= 1'b1;
        for (int i = 1; i < LATENCY; i++) begin
          exp_p[i]  <= exp_p[i-1];
          addr_p[i] <= addr_p[i-1];
          vld_p[i]  <= vld_p[i-1];
        end
      end
    end

    assign exp_c  = exp_p[LATENCY-1];
    assign addr_c = addr_p[LATENCY-1];
    assign vld_c  = vld_p[LATENCY-1];
  end

  // ---- compare point ----
  logic mis;
  assign mis = vld_c && (exp_c != i_act_vld);

  // ---- result registers: a clear wipes history before the current event is counted ----
  logic [CNT_W-1:0] hit_cnt [NUM_REGIONS];
  logic             cap_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err        <= 1'b0;
      o_err_sticky <= 1'b0;
      o_overlap    <= 1'b0;
      o_err_cnt    <= '0;
      cap_vld      <= 1'b0;
      o_first_addr <= '0;
      o_first_exp  <= '0;
      o_first_act  <= '0;
      for (int k = 0; k < NUM_REGIONS; k++) hit_cnt[k] <= '0;
    end else begin
      o_err <= mis;
      if (mis)          o_err_sticky <= 1'b1;
      if (overlap_live) o_overlap    <= 1'b1;

      if (i_clr)    o_err_cnt <= mis ? CNT_W'(1) : '0;
      else if (mis) o_err_cnt <= sat_inc(o_err_cnt);

      for (int k = 0; k < NUM_REGIONS; k++) begin
        if (i_clr)                    hit_cnt[k] <= (vld_c && exp_c[k]) ? CNT_W'(1) : '0;
        else if (vld_c && exp_c[k])   hit_cnt[k] <= sat_inc(hit_cnt[k]);
      end

      if (i_clr) begin
        cap_vld      <= mis;
        o_first_addr <= mis ? addr_c    : '0;
        o_first_exp  <= mis ? exp_c     : '0;
        o_first_act  <= mis ? i_act_vld : '0;
      end else if (mis && !cap_vld) begin
        cap_vld      <= 1'b1;
        o_first_addr <= addr_c;
        o_first_exp  <= exp_c;
        o_first_act  <= i_act_vld;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_hit_out
    assign o_hit_cnt[k*CNT_W +: CNT_W] = hit_cnt[k];
  end

endmodule

// File: tb/tb_lsu_decode_checker.sv
// Bench for lsu_decode_checker: four instances (latency 0/2/3 and an overlapping map)
// driven by directed scenarios and random traffic, checked against a history-based model.
module tb_lsu_decode_checker;

  localparam int NI = 4;
  localparam int LAT_OF [NI] = '{0, 2, 3, 0};
  localparam logic [95:0] BASE_N = {32'h7020, 32'h7000, 32'h2000};
  localparam logic [95:0] BASE_O = {32'h7020, 32'h2000, 32'h2000};
  localparam logic [95:0] SIZE_N = {32'd8, 32'd4, 32'h2000};
  localparam logic [31:0] POOL [12] = '{32'h1FFC, 32'h2000, 32'h3FFC, 32'h4000, 32'h6FFC, 32'h7000,
                                        32'h7004, 32'h701C, 32'h7020, 32'h7024, 32'h7028, 32'hFFFF_FFFC};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, drv_vld, clr;
  logic [31:0] drv_addr;
  logic [2:0]  act    [NI];
  logic        err    [NI];
  logic        sticky [NI];
  logic        ovl    [NI];
  logic [3:0]  errcnt [NI];
  logic [11:0] hitcnt [NI];
  logic [31:0] faddr  [NI];
  logic [2:0]  fexp   [NI];
  logic [2:0]  fact   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    lsu_decode_checker #(
      .NUM_REGIONS (3),
      .ADDR_W      (32),
      .LATENCY     (LAT_OF[g]),
      .CNT_W       (4),
      .REGION_BASE ((g == 3) ? BASE_O : BASE_N),
      .REGION_SIZE (SIZE_N)
    ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_drv_vld    (drv_vld),
      .i_drv_addr   (drv_addr),
      .i_act_vld    (act[g]),
      .i_clr        (clr),
      .o_err        (err[g]),
      .o_err_sticky (sticky[g]),
      .o_err_cnt    (errcnt[g]),
      .o_hit_cnt    (hitcnt[g]),
      .o_first_addr (faddr[g]),
      .o_first_exp  (fexp[g]),
      .o_first_act  (fact[g]),
      .o_overlap    (ovl[g])
    );
  end

  // driven history: index 0 is the current cycle
  logic        hv [8];
  logic [31:0] ha [8];
  int          act_lag [NI];
  logic [2:0]  inj     [NI];

  // model state
  logic        m_err [NI], m_sticky [NI], m_ovl [NI], m_capv [NI];
  int          m_errcnt [NI];
  int          m_hit [NI][3];
  logic [31:0] m_faddr [NI];
  logic [2:0]  m_fexp [NI], m_fact [NI];
  int          n_since [NI];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [2:0] ref_exp(input int i, input logic v, input logic [31:0] a);
    longint unsigned base [3];
    longint unsigned size [3];
    longint unsigned au;
    logic [2:0] r;
    r  = '0;
    au = {32'b0, a};
    base[0] = 64'h2000; base[1] = (i == 3) ? 64'h2000 : 64'h7000; base[2] = 64'h7020;
    size[0] = 64'h2000; size[1] = 64'd4; size[2] = 64'd8;
    for (int k = 0; k < 3; k++)
      if (v && size[k] != 0 && au >= base[k] && au < base[k] + size[k]) r[k] = 1'b1;
    return r;
  endfunction

  function automatic void model_edge(input int i, input logic v, input logic [31:0] a,
                                     input logic c, input logic r);
    logic [2:0] expd;
    logic       cmp, mis;
    if (r) begin
      m_err[i] = 0; m_sticky[i] = 0; m_ovl[i] = 0; m_capv[i] = 0; m_errcnt[i] = 0;
      m_faddr[i] = 0; m_fexp[i] = 0; m_fact[i] = 0; n_since[i] = 0;
      for (int k = 0; k < 3; k++) m_hit[i][k] = 0;
      return;
    end
    cmp  = (n_since[i] >= LAT_OF[i]);
    expd = cmp ? ref_exp(i, hv[LAT_OF[i]], ha[LAT_OF[i]]) : 3'b000;
    mis  = cmp && (expd != act[i]);
    m_err[i] = mis;
    if (mis) m_sticky[i] = 1;
    if ($countones(ref_exp(i, v, a)) > 1) m_ovl[i] = 1;
    if (c) begin
      m_errcnt[i] = 0; m_capv[i] = 0; m_faddr[i] = 0; m_fexp[i] = 0; m_fact[i] = 0;
      for (int k = 0; k < 3; k++) m_hit[i][k] = 0;
    end
    if (mis && m_errcnt[i] < 15) m_errcnt[i]++;
    for (int k = 0; k < 3; k++) if (expd[k] && m_hit[i][k] < 15) m_hit[i][k]++;
    if (mis && !m_capv[i]) begin
      m_capv[i] = 1; m_faddr[i] = ha[LAT_OF[i]]; m_fexp[i] = expd; m_fact[i] = act[i];
    end
    if (n_since[i] < 100) n_since[i]++;
  endfunction

  task automatic check_inst(input int i);
    check_val($sformatf("err%0d", i),      32'(err[i]),    32'(m_err[i]));
    check_val($sformatf("sticky%0d", i),   32'(sticky[i]), 32'(m_sticky[i]));
    check_val($sformatf("overlap%0d", i),  32'(ovl[i]),    32'(m_ovl[i]));
    check_val($sformatf("err_cnt%0d", i),  32'(errcnt[i]), m_errcnt[i]);
    check_val($sformatf("first_addr%0d", i), faddr[i],     m_faddr[i]);
    check_val($sformatf("first_exp%0d", i), 32'(fexp[i]),  32'(m_fexp[i]));
    check_val($sformatf("first_act%0d", i), 32'(fact[i]),  32'(m_fact[i]));
    for (int k = 0; k < 3; k++)
      check_val($sformatf("hit%0d_%0d", i, k), 32'(hitcnt[i][k*4 +: 4]), m_hit[i][k]);
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic c, input logic r);
    for (int j = 7; j > 0; j--) begin
      hv[j] = hv[j-1];
      ha[j] = ha[j-1];
    end
    hv[0] = v; ha[0] = a;
    drv_vld = v; drv_addr = a; clr = c; rst = r;
    for (int i = 0; i < NI; i++) act[i] = ref_exp(i, hv[act_lag[i]], ha[act_lag[i]]) ^ inj[i];
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_edge(i, v, a, c, r);
    for (int i = 0; i < NI; i++) inj[i] = 3'b000;
    #1;
    for (int i = 0; i < NI; i++) check_inst(i);
  endtask

  initial begin
    rst = 1'b1; drv_vld = 1'b0; drv_addr = '0; clr = 1'b0;
    for (int j = 0; j < 8; j++) begin hv[j] = 1'b0; ha[j] = '0; end
    for (int i = 0; i < NI; i++) begin
      act[i] = '0; inj[i] = '0; act_lag[i] = LAT_OF[i];
      model_edge(i, 1'b0, '0, 1'b0, 1'b1);
    end

    // reset state
    step(1'b0, 32'h5555, 1'b0, 1'b1);
    step(1'b0, 32'h5555, 1'b0, 1'b1);
    check_val("rst_err_cnt", 32'(errcnt[0]), 0);
    check_val("rst_hit_cnt", 32'(hitcnt[1]), 0);
    check_val("rst_first_addr", faddr[2], 0);
    check_val("rst_sticky", 32'(sticky[3]), 0);

    // matching accesses, latency 0
    step(1'b1, 32'h2000, 1'b0, 1'b0);
    step(1'b1, 32'h3FFC, 1'b0, 1'b0);
    step(1'b1, 32'h7024, 1'b0, 1'b0);
    check_val("s1_hit0", 32'(hitcnt[0][3:0]), 2);
    check_val("s1_hit1", 32'(hitcnt[0][7:4]), 0);
    check_val("s1_hit2", 32'(hitcnt[0][11:8]), 1);
    check_val("s1_err_cnt", 32'(errcnt[0]), 0);
    check_val("s5_overlap_set", 32'(ovl[3]), 1);
    check_val("s5_no_overlap", 32'(ovl[0]), 0);

    // just past region 0 while the decoder selects region 0
    inj[0] = 3'b001;
    step(1'b1, 32'h4000, 1'b0, 1'b0);
    check_val("s2_err", 32'(err[0]), 1);
    check_val("s2_first_addr", faddr[0], 32'h4000);
    check_val("s2_first_exp", 32'(fexp[0]), 0);
    check_val("s2_first_act", 32'(fact[0]), 1);
    check_val("s2_err_cnt", 32'(errcnt[0]), 1);
    step(1'b0, 32'h5555, 1'b0, 1'b0);
    check_val("s2_err_pulse", 32'(err[0]), 0);

    // latency 2: correctly aligned so far, then decoder one cycle early
    step(1'b0, 32'h5555, 1'b0, 1'b0);
    check_val("s3_aligned_ok", 32'(errcnt[1]), 0);
    step(1'b0, 32'h5555, 1'b1, 1'b0);
    act_lag[1] = 1;
    step(1'b1, 32'h7000, 1'b0, 1'b0);
    step(1'b1, 32'h7020, 1'b0, 1'b0);
    check_val("s3_err", 32'(err[1]), 1);
    check_val("s3_first_addr", faddr[1], 32'h5555);
    check_val("s3_first_act", 32'(fact[1]), 3'b010);
    step(1'b1, 32'h2000, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) step(1'b0, 32'h5555, 1'b0, 1'b0);
    check_val("s3_first_hold", faddr[1], 32'h5555);
    check_val("s3_first_act_hold", 32'(fact[1]), 3'b010);
    check_val("s3_err_cnt", 32'(errcnt[1]), 4);
    act_lag[1] = 2;
    for (int n = 0; n < 3; n++) step(1'b0, 32'h5555, 1'b0, 1'b0);

    // hit counter saturation, then clear together with a hit
    for (int n = 0; n < 20; n++) step(1'b1, 32'h7000, 1'b0, 1'b0);
    check_val("s4_sat", 32'(hitcnt[0][7:4]), 15);
    step(1'b1, 32'h7000, 1'b1, 1'b0);
    check_val("s4_clr_hit", 32'(hitcnt[0][7:4]), 1);
    check_val("s4_clr_hit_lat2", 32'(hitcnt[1][7:4]), 1);
    check_val("s5_overlap_kept", 32'(ovl[3]), 1);

    // reset with traffic in flight on the latency-3 instance
    act_lag[2] = 0;
    step(1'b1, 32'h7000, 1'b0, 1'b0);
    step(1'b1, 32'h7020, 1'b0, 1'b0);
    act_lag[2] = 3;
    step(1'b1, 32'h7024, 1'b0, 1'b1);
    check_val("s5_overlap_rst", 32'(ovl[3]), 0);
    for (int n = 0; n < 3; n++) begin
      inj[2] = 3'b111;
      step(1'b1, 32'h7000, 1'b0, 1'b0);
      check_val("s6_no_err", 32'(err[2]), 0);
      check_val("s6_err_cnt", 32'(errcnt[2]), 0);
      check_val("s6_hit_cnt", 32'(hitcnt[2]), 0);
    end
    inj[2] = 3'b111;
    step(1'b1, 32'h7000, 1'b0, 1'b0);
    check_val("s6_first_compare", 32'(err[2]), 1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic        v, c, r;
      a = ($urandom_range(0, 7) == 0) ? $urandom() : POOL[$urandom_range(0, 11)];
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(0, 15) == 0)     act_lag[i] = $urandom_range(0, 4);
        else if ($urandom_range(0, 3) == 0) act_lag[i] = LAT_OF[i];
        inj[i] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      end
      step(v, a, c, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_decode_checker.md
Name: lsu_decode_checker

Overview:
Synthesizable checker for the LSU address decoder, usable in the bench and in FPGA debug builds.
- Recomputes the expected one-hot peripheral-select vector from the driven LSU address, for a parametrised number of regions.
- Delays that expectation by a programmable decoder latency and compares it against the actual select lines.
- Keeps per-region hit counters, an error counter and a first-error capture record.
- Sits beside the LSU and taps its address/valid inputs and its region-select outputs.

Parameters:
NUM_REGIONS, 8, number of decoded regions (1..16)
ADDR_W, 32, address width
LATENCY, 0, pipeline cycles between address and select lines in the decoder (0..4)
CNT_W, 16, width of every counter
REGION_BASE, rv32i_pkg defaults, packed NUM_REGIONS*ADDR_W base addresses; region k occupies bits [k*ADDR_W +: ADDR_W]
REGION_SIZE, rv32i_pkg defaults, packed NUM_REGIONS*ADDR_W region sizes in bytes; size 0 disables the region

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_drv_vld  in  1  LSU access valid
i_drv_addr  in  ADDR_W  LSU access address
i_act_vld  in  NUM_REGIONS  decoder select outputs; bit k is region k
i_clr  in  1  synchronous clear of counters and capture; the sticky flag is kept
o_err  out  1  one-cycle pulse on a mismatch
o_err_sticky  out  1  set on the first mismatch; cleared only by i_rst
o_err_cnt  out  CNT_W  saturating count of mismatch cycles
o_hit_cnt  out  NUM_REGIONS*CNT_W  saturating per-region count of expected hits
o_first_addr  out  ADDR_W  address of the first mismatch
o_first_exp  out  NUM_REGIONS  expected vector at the first mismatch
o_first_act  out  NUM_REGIONS  actual vector at the first mismatch
o_overlap  out  1  sticky flag: an address matched more than one region (configuration error)

Behaviour:
- Expected vector: exp[k] = i_drv_vld && size_k!=0 && addr>=base_k && addr<base_k+size_k.
- The upper bound is computed in ADDR_W+1 bits, so a region ending at 2^ADDR_W does not wrap.
- Delay line: exp, addr and a stage-valid bit shift through LATENCY register stages.
- Compare point: the tail of the delay line (or the live values when LATENCY=0). mis = stage_valid && (exp_d != i_act_vld).
- Output timing: all outputs are registered. o_err and the counter updates appear one cycle after the compare cycle.
- Stage-valid bits reset to 0, so no compare happens during the first LATENCY cycles after reset release.
- o_hit_cnt[k] increments when exp_d[k] && stage_valid. o_err_cnt increments on mis. Both saturate at all-ones; they never wrap.
- First-error capture loads on mis only while the capture-valid bit is clear, then holds. i_clr clears the capture-valid bit and the capture registers.
- i_clr together with mis in the same cycle: the clear applies first, then the event is counted. Result: o_err_cnt=1 and the capture loads this event.
- i_clr together with a hit: the hit count becomes 1.
- o_overlap is set when popcount(exp) > 1, checked at the input stage; it is sticky until reset.
- Reset mid-operation flushes the delay line; events in flight are discarded.
- Reset values: every output 0, every pipeline register 0.
- No handshake; the block is purely observational.

Decomposition:
- rv32i_pkg: the existing *_BASE_ADDR constants plus new *_SIZE constants.
- rv32i_pkg: the DEF_REGION_BASE and DEF_REGION_SIZE packed defaults (8 regions: data_mem, ledr, ledg, seg7, lcd, sw, btn, timer).
- rv32i_pkg: localparam MAX_REGIONS=16.
- Sub-module lsu_region_match: combinational; address plus parameters in, exp vector and overlap flag out. The bench reuses it as its reference model.
- Delay line, counters and capture stay in the top module.

Test Plan:
Common configuration for all scenarios: NUM_REGIONS=3; bases 0x2000, 0x7000, 0x7020; sizes 0x2000, 4, 8; CNT_W=4.
1. LATENCY=0; addr 0x2000, 0x3FFC, 0x7024 with i_drv_vld=1 and matching i_act_vld -> o_err never rises; hit counts are 2, 0, 1.
2. LATENCY=0; addr 0x4000 (just past region 0) with i_act_vld=3'b001 -> o_err pulses one cycle later; o_first_addr=0x4000, o_first_exp=0, o_first_act=3'b001; o_err_cnt=1.
3. LATENCY=2; act mirrors exp delayed by 2 cycles -> no error. Act delayed by only 1 cycle -> mismatch pulses; first capture holds the first event only.
4. 20 consecutive hits on 0x7000 -> o_hit_cnt[1] saturates at 15. Then assert i_clr together with a hit -> count = 1.
5. Override region 1 base to 0x2000 and access 0x2000 -> o_overlap=1 and stays 1 until i_rst.
6. LATENCY=3; assert i_rst with an erroneous access in flight -> after release, o_err stays 0 for 3 cycles and all counters read 0.
